// File: rtl/i2s_pkg.sv
// i2s_pkg: shared FSM encoding, framing constants and index sizing for the I2S receiver
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, PAD} state_t;
  localparam int I2S_DELAY_BITS = 1;
  localparam bit CH_LEFT = 1'b0;
  localparam bit CH_RIGHT = 1'b1;
  function automatic int clog2(input int v);
    return $clog2(v);
  endfunction
endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// i2s_rx_deserializer_if: serial I2S inputs and word/strobe outputs of the receiver
interface i2s_rx_deserializer_if #(
  parameter int DATA_WIDTH = 24
);
  logic i_bclk;
  logic i_lrclk;
  logic i_sdata;
  logic o_en;
  logic o_frame_err;
  logic [DATA_WIDTH-1:0] ov_dout;
  modport master (output i_bclk, i_lrclk, i_sdata, input o_en, o_frame_err, ov_dout);
  modport slave (input i_bclk, i_lrclk, i_sdata, output o_en, o_frame_err, ov_dout);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer plus previous-value register giving the level and a rise strobe
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], d};
  always_ff @(posedge clk) sh_q <= rst ? '0 : sh_d;
  assign q = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: synchronizes an async I2S stream and deserializes one channel into
// DATA_WIDTH-bit words with a one-cycle strobe; framing faults pulse o_frame_err.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter bit CHANNEL = CH_LEFT
) (
  input logic i_clk,
  input logic i_rst,
  i2s_rx_deserializer_if.slave bus
);
  localparam int IDX_W = clog2(SLOT_WIDTH + 1);
  localparam int LAST = DATA_WIDTH + I2S_DELAY_BITS - 1;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, dout_q, dout_d;
  logic lr_q, lr_d, en_q, en_d, err_q, err_d;
  logic bclk_rise, lr_s, sd_s, unused_bclk;
  logic [1:0] unused_rise;
  sync_edge u_bclk (.clk(i_clk), .rst(i_rst), .d(bus.i_bclk), .q(unused_bclk), .rise(bclk_rise));
  sync_edge u_lrclk (.clk(i_clk), .rst(i_rst), .d(bus.i_lrclk), .q(lr_s), .rise(unused_rise[0]));
  sync_edge u_sdata (.clk(i_clk), .rst(i_rst), .d(bus.i_sdata), .q(sd_s), .rise(unused_rise[1]));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sr_d = sr_q;
    dout_d = dout_q;
    lr_d = lr_q;
    en_d = 1'b0;
    err_d = 1'b0;
    if (bclk_rise) begin
      lr_d = lr_s;
      if (lr_s != lr_q) begin
        // an LRCLK edge always opens a new slot; a word still being shifted is lost
        state_d = SYNC;
        idx_d = '0;
        err_d = state_q inside {SYNC, SHIFT};
      end else if (state_q != IDLE) begin
        idx_d = idx_q + 1'b1;
        if (state_q inside {SYNC, SHIFT}) begin
          sr_d = {sr_q[DATA_WIDTH-2:0], sd_s};
          state_d = (idx_d == IDX_W'(LAST)) ? PAD : SHIFT;
          en_d = (idx_d == IDX_W'(LAST)) && (lr_s == CHANNEL);
          dout_d = en_d ? sr_d : dout_q;
        end
        if (idx_d == IDX_W'(SLOT_WIDTH)) begin
          state_d = IDLE;
          err_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      sr_q <= '0;
      dout_q <= '0;
      lr_q <= 1'b0;
      en_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sr_q <= sr_d;
      dout_q <= dout_d;
      lr_q <= lr_d;
      en_q <= en_d;
      err_q <= err_d;
    end
  end
  assign bus.o_en = en_q;
  assign bus.o_frame_err = err_q;
  assign bus.ov_dout = dout_q;
endmodule

// File: doc/i2s_rx_deserializer.md
# i2s_rx_deserializer

Front-end stage that feeds the FIR filter: receives a standard I2S serial audio stream (BCLK, LRCLK, SDATA) that is asynchronous to the system clock. It synchronizes the stream into `i_clk`, deserializes one selected channel into `DATA_WIDTH`-bit two's-complement words, and emits each word with a one-cycle strobe. `o_en`/`ov_dout` connect directly to the filter's `i_en`/`iv_din`; framing faults are flagged and the faulty word is discarded.

## Interface
- `DATA_WIDTH`, 24: captured word width, MSB first.
- `SLOT_WIDTH`, 32: BCLK periods per channel slot; must be ≥ `DATA_WIDTH`+1.
- `CHANNEL`, 0: channel captured; 0 = left (LRCLK low), 1 = right (LRCLK high).
- `i_clk` in 1: system clock; must be ≥ 4× BCLK frequency.
- `i_rst` in 1: synchronous, active-high reset.
- `i_bclk` in 1: I2S bit clock, asynchronous.
- `i_lrclk` in 1: I2S word select, asynchronous.
- `i_sdata` in 1: I2S serial data, asynchronous.
- `o_en` out 1: one-cycle strobe; new word valid on `ov_dout`.
- `ov_dout` out `DATA_WIDTH`: last captured word; holds its value between strobes.
- `o_frame_err` out 1: one-cycle pulse when a framing fault is detected.

## Operation
- `i_bclk`, `i_lrclk` and `i_sdata` pass through identical 2-FF synchronizers, so they stay mutually aligned. A third register on the synchronized BCLK gives `bclk_rise`. All stream processing happens only in cycles where `bclk_rise` is high.
- Slot index `idx` counts `bclk_rise` events since the last LRCLK change.
  - The rise on which synchronized LRCLK differs from its previous sampled value sets `idx` = 0. This is the I2S delay bit and is ignored.
  - `idx` 1..`DATA_WIDTH` shift `i_sdata` into the shift register, MSB first.
  - `idx` > `DATA_WIDTH` is padding and is ignored.
- States:
  - **IDLE**: ignore data; on an LRCLK change go to SYNC.
  - **SYNC**: `idx` = 0 handling, then go to SHIFT.
  - **SHIFT**: capture bits; on `idx` = `DATA_WIDTH` go to PAD. If the slot's channel equals `CHANNEL`, register the word into `ov_dout` and pulse `o_en`.
  - **PAD**: wait; on an LRCLK change go to SYNC.
- Non-selected channel: traversed identically, including error checks, but no `o_en` and no `ov_dout` update.
- Short slot (LRCLK changes while in SHIFT): pulse `o_frame_err`, discard the partial word, no `o_en`, and go to SYNC, treating that rise as the new slot's `idx` 0.
- Long slot (`idx` reaches `SLOT_WIDTH` without an LRCLK change): pulse `o_frame_err` and go to IDLE.
- Reset:
  - All state is cleared. `o_en` = 0, `o_frame_err` = 0, `ov_dout` = 0, state = IDLE, `idx` = 0, synchronizers = 0.
  - Reset mid-word discards the word with no strobe.
  - After reset, nothing is captured until the first LRCLK change.
- No arithmetic; the bit stream is transferred unmodified, including sign.

## Timing
- Latency: `o_en` is high during the cycle after the 3rd rising `i_clk` edge, counting from the edge that first samples the LSB's BCLK high. This covers 2 synchronizer edges plus 1 output register edge.
- `ov_dout` changes on the same edge that raises `o_en` and is stable for ≥ 1 BCLK period.
- `o_en` and `o_frame_err` are each exactly 1 cycle wide. They are never high in the same cycle.
- At most one `o_en` per LRCLK frame.
- Minimum spacing between strobes: 2×`SLOT_WIDTH` BCLK periods.
- `i_rst` overrides all other activity in its cycle.

## Structure
- Shared package `i2s_pkg`:
  - State encoding: IDLE, SYNC, SHIFT, PAD.
  - Constant `I2S_DELAY_BITS` = 1.
  - Channel constants `CH_LEFT` = 0, `CH_RIGHT` = 1.
  - clog2 helper for the `idx` width, clog2(`SLOT_WIDTH`+1).
- Sub-module `sync_edge`: 2-FF synchronizer plus previous-value register. Outputs the synchronized level and a rise strobe. Instantiated for BCLK; the LRCLK and SDATA chains use the same module with the rise output unused.

## Test plan
- **Nominal left:** `CHANNEL`=0, `i_clk` = 8× BCLK, `SLOT_WIDTH`=32, left 0x123456 / right 0xABCDEF for 4 frames → 4 `o_en` pulses, `ov_dout` = 0x123456, `o_frame_err` never high.
- **Right channel:** same stream with `CHANNEL`=1 → `ov_dout` = 0xABCDEF, one `o_en` per frame, strobe on the right slot's LSB.
- **Extremes at minimum ratio:** `i_clk` = 4× BCLK, left words 0x7FFFFF then 0x800000 → exact values, `o_en` at 3-cycle latency after the LSB rise is first sampled.
- **Short slot:** LRCLK toggles after 16 data bits of the left slot → one `o_frame_err` pulse, no `o_en` that frame. Next full frame 0x000001 → `o_en` with `ov_dout` = 0x000001.
- **Long slot:** LRCLK held for 40 BCLKs → `o_frame_err` at `idx` = 32, state IDLE, no `o_en`. Capture resumes after the next LRCLK change.
- **Reset mid-word:** `i_rst` for 2 cycles after 10 bits of 0x5A5A5A → `ov_dout` = 0, no `o_en` for the interrupted word. First strobe occurs only after a subsequent LRCLK change.
